// File: rtl/result_requant_drain.sv
// result_requant_drain
// Drains the int32 result matrix of the NxN systolic array one row at a time.
// Each row is requantized to int8 (multiply, rounding right shift, optional
// ReLU, saturate) and offered downstream as one valid/ready beat.
//
// Optional feature: define REQUANT_BIAS_EN to add a per-column signed bias
// port that is sampled at mm_done and added to each accumulator before the
// multiply.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   mm_done           done pulse from the array; starts a drain from IDLE
//   rd_row_addr       row read address to the array (data returns next cycle)
//   rd_data           result row, ARRAY_SIZE lanes of ACC_WIDTH, lane 0 in LSBs
//   cfg_mult          signed requant multiplier (sampled at mm_done)
//   cfg_shift         rounding right-shift amount (sampled at mm_done)
//   cfg_relu          clamp negatives to zero (sampled at mm_done)
//   bias              per-column signed bias (REQUANT_BIAS_EN only)
//   busy              drain in progress
//   out_valid/ready   output row handshake
//   out_row_addr      index of the row on out_data
//   out_data          ARRAY_SIZE lanes of DATA_WIDTH, lane 0 in LSBs
//   out_last          set with the final row
//   drain_done        one-cycle pulse after the final row is accepted
module result_requant_drain #(
   parameter int unsigned ARRAY_SIZE  = 8,
   parameter int unsigned DATA_WIDTH  = 8,
   parameter int unsigned ACC_WIDTH   = 32,
   parameter int unsigned ADDR_WIDTH  = $clog2(ARRAY_SIZE),
   parameter int unsigned MULT_WIDTH  = 16,
   parameter int unsigned SHIFT_WIDTH = 5
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic                                mm_done,
   output logic [ADDR_WIDTH-1:0]               rd_row_addr,
   input  logic [ARRAY_SIZE*ACC_WIDTH-1:0]     rd_data,
   input  logic signed [MULT_WIDTH-1:0]        cfg_mult,
   input  logic [SHIFT_WIDTH-1:0]              cfg_shift,
   input  logic                                cfg_relu,
`ifdef REQUANT_BIAS_EN
   input  logic [ARRAY_SIZE*ACC_WIDTH-1:0]     bias,
`endif
   output logic                                busy,
   output logic                                out_valid,
   input  logic                                out_ready,
   output logic [ADDR_WIDTH-1:0]               out_row_addr,
   output logic [ARRAY_SIZE*DATA_WIDTH-1:0]    out_data,
   output logic                                out_last,
   output logic                                drain_done
);

   // Lane datapath widths: pre-multiply sum, full product, product plus a
   // guard bit so the rounding increment can never overflow.
`ifdef REQUANT_BIAS_EN
   localparam int unsigned SUM_W  = ACC_WIDTH + 1;
`else
   localparam int unsigned SUM_W  = ACC_WIDTH;
`endif
   localparam int unsigned PROD_W = SUM_W + MULT_WIDTH;
   localparam int unsigned RND_W  = PROD_W + 1;

   localparam logic signed [RND_W-1:0] SAT_MAX =
      RND_W'((64'sd1 <<< (DATA_WIDTH - 1)) - 64'sd1);
   localparam logic signed [RND_W-1:0] SAT_MIN = ~SAT_MAX;

   localparam logic [ADDR_WIDTH-1:0] LAST_ROW = ADDR_WIDTH'(ARRAY_SIZE - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_READ = 2'd1,
      ST_CALC = 2'd2,
      ST_OUT  = 2'd3
   } state_t;

   state_t                             state_q, state_d;
   logic [ADDR_WIDTH-1:0]              row_q, row_d;
   logic [ADDR_WIDTH-1:0]              rd_row_addr_d;
   logic                               busy_d;
   logic                               out_valid_d;
   logic [ADDR_WIDTH-1:0]              out_row_addr_d;
   logic [ARRAY_SIZE*DATA_WIDTH-1:0]   out_data_d;
   logic                               out_last_d;
   logic                               drain_done_d;

   // Configuration shadows, frozen for the whole drain
   logic signed [MULT_WIDTH-1:0]       mult_q, mult_d;
   logic [SHIFT_WIDTH-1:0]             shift_q, shift_d;
   logic                               relu_q, relu_d;
`ifdef REQUANT_BIAS_EN
   logic [ARRAY_SIZE*ACC_WIDTH-1:0]    bias_q, bias_d;
`endif

   logic [ARRAY_SIZE*DATA_WIDTH-1:0]   lane_res_c;

   // One lane: full-precision product, round-half-up shift, ReLU, saturate.
   function automatic logic [DATA_WIDTH-1:0] requant(
      input logic signed [SUM_W-1:0]      s,
      input logic signed [MULT_WIDTH-1:0] m,
      input logic [SHIFT_WIDTH-1:0]       sh,
      input logic                         relu
   );
      logic signed [PROD_W-1:0] p;
      logic signed [RND_W-1:0]  half;
      logic signed [RND_W-1:0]  r;
      p    = PROD_W'(s) * PROD_W'(m);
      half = '0;
      if (sh != '0) begin
         half = RND_W'(1) << (sh - SHIFT_WIDTH'(1));
      end
      r = RND_W'(p) + half;
      r = r >>> sh;
      if (relu && r[RND_W-1]) begin
         r = '0;
      end
      if (r > SAT_MAX) begin
         r = SAT_MAX;
      end else if (r < SAT_MIN) begin
         r = SAT_MIN;
      end
      return DATA_WIDTH'(r);
   endfunction

   // All lanes in parallel from the row currently on rd_data
   always_comb begin
      logic signed [SUM_W-1:0] sum_v;
      lane_res_c = '0;
      for (int c = 0; c < int'(ARRAY_SIZE); c++) begin
`ifdef REQUANT_BIAS_EN
         sum_v = SUM_W'($signed(rd_data[c*ACC_WIDTH +: ACC_WIDTH]))
               + SUM_W'($signed(bias_q[c*ACC_WIDTH +: ACC_WIDTH]));
`else
         sum_v = $signed(rd_data[c*ACC_WIDTH +: ACC_WIDTH]);
`endif
         lane_res_c[c*DATA_WIDTH +: DATA_WIDTH] = requant(sum_v, mult_q, shift_q, relu_q);
      end
   end

   // Next-state and next-output logic
   always_comb begin
      state_d        = state_q;
      row_d          = row_q;
      rd_row_addr_d  = rd_row_addr;
      busy_d         = busy;
      out_valid_d    = out_valid;
      out_row_addr_d = out_row_addr;
      out_data_d     = out_data;
      out_last_d     = out_last;
      drain_done_d   = 1'b0;
      mult_d         = mult_q;
      shift_d        = shift_q;
      relu_d         = relu_q;
`ifdef REQUANT_BIAS_EN
      bias_d         = bias_q;
`endif

      unique case (state_q)
         ST_IDLE: begin
            // drain_done is high during the first IDLE cycle; a coincident
            // mm_done is deliberately dropped there.
            if (mm_done && !drain_done) begin
               mult_d        = cfg_mult;
               shift_d       = cfg_shift;
               relu_d        = cfg_relu;
`ifdef REQUANT_BIAS_EN
               bias_d        = bias;
`endif
               row_d         = '0;
               rd_row_addr_d = '0;
               busy_d        = 1'b1;
               state_d       = ST_READ;
            end
         end
         ST_READ: begin
            // rd_row_addr already presents row; the array answers next cycle
            state_d = ST_CALC;
         end
         ST_CALC: begin
            out_data_d     = lane_res_c;
            out_row_addr_d = row_q;
            out_last_d     = (row_q == LAST_ROW);
            out_valid_d    = 1'b1;
            state_d        = ST_OUT;
         end
         ST_OUT: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               if (out_last) begin
                  drain_done_d = 1'b1;
                  busy_d       = 1'b0;
                  state_d      = ST_IDLE;
               end else begin
                  row_d         = row_q + ADDR_WIDTH'(1);
                  rd_row_addr_d = row_q + ADDR_WIDTH'(1);
                  state_d       = ST_READ;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         row_q        <= '0;
         rd_row_addr  <= '0;
         busy         <= 1'b0;
         out_valid    <= 1'b0;
         out_row_addr <= '0;
         out_data     <= '0;
         out_last     <= 1'b0;
         drain_done   <= 1'b0;
         mult_q       <= '0;
         shift_q      <= '0;
         relu_q       <= 1'b0;
`ifdef REQUANT_BIAS_EN
         bias_q       <= '0;
`endif
      end else begin
         state_q      <= state_d;
         row_q        <= row_d;
         rd_row_addr  <= rd_row_addr_d;
         busy         <= busy_d;
         out_valid    <= out_valid_d;
         out_row_addr <= out_row_addr_d;
         out_data     <= out_data_d;
         out_last     <= out_last_d;
         drain_done   <= drain_done_d;
         mult_q       <= mult_d;
         shift_q      <= shift_d;
         relu_q       <= relu_d;
`ifdef REQUANT_BIAS_EN
         bias_q       <= bias_d;
`endif
      end
   end

endmodule

// File: doc/result_requant_drain.md
Name: result_requant_drain

Overview:
- Downstream stage of the NxN systolic accelerator.
- On the array's done pulse, reads the int32 result matrix row by row through the array's read port.
- Requantizes each element to int8 (multiply, rounding right shift, optional ReLU, saturate).
- Streams one output row per valid/ready beat to the next layer's buffer.

Parameters:
- ARRAY_SIZE, 8, rows/columns of the result matrix
- DATA_WIDTH, 8, output element width (signed)
- ACC_WIDTH, 32, accumulator element width (signed)
- ADDR_WIDTH, $clog2(ARRAY_SIZE), row address width
- MULT_WIDTH, 16, requant multiplier width (signed)
- SHIFT_WIDTH, 5, requant shift width (unsigned)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- mm_done  in  1  done pulse from the systolic array
- rd_row_addr  out  ADDR_WIDTH  result row read address to the array
- rd_data  in  ARRAY_SIZE x ACC_WIDTH  result row; valid 1 cycle after rd_row_addr
- cfg_mult  in  MULT_WIDTH  signed requant multiplier
- cfg_shift  in  SHIFT_WIDTH  right shift amount, 0..31
- cfg_relu  in  1  clamp negatives to 0
- busy  out  1  drain in progress
- out_valid  out  1  output row valid
- out_ready  in  1  consumer accepts row
- out_row_addr  out  ADDR_WIDTH  index of current output row
- out_data  out  ARRAY_SIZE x DATA_WIDTH  requantized signed row
- out_last  out  1  high with the final row (row ARRAY_SIZE-1)
- drain_done  out  1  one-cycle pulse after the final row is accepted

Behaviour:
- Single clock domain. Reset is asynchronous and active-low.
- Reset values: all outputs 0; FSM in IDLE; row counter 0.
- FSM states: IDLE, READ, CALC, OUT.
- IDLE:
  - On mm_done=1: sample cfg_mult, cfg_shift and cfg_relu into shadow registers, set row=0, busy=1, go to READ.
  - The config inputs are don't-care after sampling.
- READ: drive rd_row_addr=row, then go to CALC.
  - rd_row_addr holds its last value in all other states.
- CALC:
  - rd_data is valid this cycle.
  - Compute all ARRAY_SIZE lanes in parallel; register the results into out_data.
  - Set out_row_addr=row and out_last=(row==ARRAY_SIZE-1).
  - Go to OUT with out_valid=1 on the next cycle.
- OUT:
  - Hold out_valid, out_data, out_row_addr and out_last stable while out_ready=0.
  - On out_valid&&out_ready, deassert out_valid next cycle.
  - If not the last row: row++, go to READ.
  - If the last row: pulse drain_done 1 cycle, busy=0, go to IDLE.
- Throughput: 3 cycles/row minimum with out_ready=1. mm_done to first out_valid: 3 cycles.
- Per-lane arithmetic, all signed:
  - p = acc * mult, ACC_WIDTH+MULT_WIDTH bits, full precision.
  - shift=0: r = p.
  - shift>0: r = (p + (1<<(shift-1))) >>> shift (round half toward +inf, arithmetic shift).
  - relu=1 and r<0: r = 0.
  - Saturate r to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1], i.e. [-128, 127].
- mm_done while busy: ignored, with no restart or corruption.
- mm_done in the same cycle as drain_done: ignored. A new drain starts only from IDLE.
- Reset mid-drain: immediate return to reset values. No drain_done pulse.
- Row counter never wraps. The drain ends after exactly ARRAY_SIZE accepted rows.

Optional Feature:
- Macro: REQUANT_BIAS_EN
- Defined:
  - Adds input port bias  in  ARRAY_SIZE x ACC_WIDTH, signed per-column bias, sampled at mm_done into shadow registers.
  - Each lane computes s = acc + bias[col] in ACC_WIDTH+1 bits, then p = s * mult.
  - Rest of the path unchanged. Latency unchanged.
- Undefined: no bias port, no bias registers; p = acc * mult.

Test Plan:
- Passthrough: mult=1, shift=0, relu=0, row 0 = {5,-3,200,-200,127,-128,0,1} -> out_data {5,-3,127,-128,127,-128,0,1}, out_row_addr=0.
- Rounding/shift: mult=3, shift=2, inputs {1,2,-2,-3,10} -> p {3,6,-6,-9,30} -> out {1,2,-1,-2,8}. Also relu=1 with input -50 -> 0.
- Full drain with out_ready=1:
  - 8 rows, first out_valid 3 cycles after mm_done, one row every 3 cycles.
  - out_last only on row 7; drain_done pulses the cycle after row-7 acceptance; busy falls with it.
- Backpressure: out_ready=0 for 5 cycles on row 2 -> out_data, out_row_addr=2 and rd_row_addr held stable. No row skipped or duplicated; golden compare of all 64 elements.
- Robustness: second mm_done pulse during row 4 -> ignored, exactly 8 rows emitted.
- Reset mid-drain: rst_n low during OUT of row 3 -> all outputs 0 immediately. A subsequent mm_done drains from row 0 correctly.
